// File: rtl/pwm_config_mc.sv
// PWM parameter frame parser: validates UDP parameter frames and converts
// frequency/duty into period and high-level counts with a serial restoring divider.
module pwm_config_mc #(
  parameter int unsigned CLK_FREQ_HZ    = 100000000,
  parameter logic [7:0]  PWM_PARAM_TYPE = 8'h01,
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned CNT_W          = 28,
  parameter int unsigned DIV_W          = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rx_axis_udp_tdata,
  input  logic             rx_axis_udp_tvalid,
  input  logic             rx_axis_udp_tlast,
  input  logic [7:0]       rx_axis_udp_tuser,
  output logic             pwm_config_vld,
  output logic [7:0]       pwm_config_channel,
  output logic             pwm_en,
  output logic [CNT_W-1:0] pwm_period,
  output logic [CNT_W-1:0] pwm_hlevel,
  output logic             cfg_err,
  output logic [2:0]       cfg_err_code,
  output logic [15:0]      frame_ok_cnt,
  output logic [15:0]      frame_err_cnt,
  output logic             busy
);

  localparam int unsigned BC_W = $clog2(DIV_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DIV_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_DIV_P, S_DIV_H, S_OUT} state_t;

  state_t state_q, state_d;

  logic             in_vld_q, in_last_q;
  logic [31:0]      in_data_q;
  logic [7:0]       in_user_q;

  logic             skip_q, skip_d, drop_q, drop_d, pend_q, pend_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [7:0]       ch_q, ch_d, duty_q, duty_d;
  logic [31:0]      freq_q, freq_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0] per_q, per_d, hl_q, hl_d;

  logic             vld_q, vld_d, oen_q, oen_d, err_q, err_d;
  logic [7:0]       och_q, och_d;
  logic [CNT_W-1:0] oper_q, oper_d, ohl_q, ohl_d;
  logic [2:0]       ecode_q, ecode_d;
  logic [15:0]      okcnt_q, okcnt_d, errcnt_q, errcnt_d;

  // One restoring-division step; the quotient shifts into the dividend register.
  logic [DIV_W:0]       shifted;
  logic                 ge;
  logic [DIV_W-1:0]     step_rem, quo;
  logic [CNT_W+6:0]     prod;

  assign shifted  = {rem_q, dvd_q[DIV_W-1]};
  assign ge       = shifted[DIV_W] | (shifted[DIV_W-1:0] >= dvs_q);
  assign step_rem = ge ? (shifted[DIV_W-1:0] - dvs_q) : shifted[DIV_W-1:0];
  assign quo      = {dvd_q[DIV_W-2:0], ge};
  assign prod     = (CNT_W+7)'(quo[CNT_W-1:0]) * (CNT_W+7)'(duty_q[6:0]);

  logic sof, busy_w, err_fire, new_pend, pend_issue;
  logic [2:0] err_code;

  assign busy_w = (state_q == S_DIV_P) || (state_q == S_DIV_H) || (state_q == S_OUT);
  assign sof    = in_vld_q && !skip_q && !drop_q && (state_q != S_RECV);

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    drop_d   = drop_q;
    wcnt_d   = wcnt_q;
    ch_d     = ch_q;
    freq_d   = freq_q;
    duty_d   = duty_q;
    en_d     = en_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    bcnt_d   = bcnt_q;
    per_d    = per_q;
    hl_d     = hl_q;
    vld_d    = 1'b0;
    och_d    = och_q;
    oen_d    = oen_q;
    oper_d   = oper_q;
    ohl_d    = ohl_q;
    okcnt_d  = okcnt_q;
    err_d    = 1'b0;
    ecode_d  = ecode_q;
    errcnt_d = errcnt_q;
    err_fire = 1'b0;
    err_code = 3'd0;
    new_pend = 1'b0;

    // Frames that are skipped (foreign type) or dropped (arrived while busy).
    if (sof && in_user_q != PWM_PARAM_TYPE) begin
      skip_d = !in_last_q;
    end else if (sof && busy_w) begin
      if (in_last_q) new_pend = 1'b1;
      else           drop_d   = 1'b1;
    end
    if (in_vld_q && in_last_q && skip_q) skip_d = 1'b0;
    if (in_vld_q && in_last_q && drop_q) begin
      drop_d   = 1'b0;
      new_pend = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sof && in_user_q == PWM_PARAM_TYPE) begin
          ch_d   = in_data_q[7:0];
          wcnt_d = 3'd1;
          if (in_last_q) begin
            err_fire = 1'b1;
            err_code = 3'd1;
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (in_vld_q) begin
          case (wcnt_q)
            3'd1:    freq_d = in_data_q;
            3'd2:    duty_d = in_data_q[7:0];
            3'd4:    en_d   = in_data_q[0];
            default: ;
          endcase
          if (wcnt_q != 3'd7) wcnt_d = wcnt_q + 3'd1;
          if (in_last_q) begin
            state_d = S_IDLE;
            if (wcnt_q != 3'd4) begin
              err_fire = 1'b1; err_code = 3'd1;
            end else if (32'(ch_q) >= NUM_CH) begin
              err_fire = 1'b1; err_code = 3'd2;
            end else if (freq_q == 32'd0) begin
              err_fire = 1'b1; err_code = 3'd3;
            end else if (duty_q > 8'd100) begin
              err_fire = 1'b1; err_code = 3'd4;
            end else begin
              state_d = S_DIV_P;
              dvd_d   = DIV_W'(CLK_FREQ_HZ);
              dvs_d   = DIV_W'(freq_q);
              rem_d   = '0;
              bcnt_d  = '0;
            end
          end
        end
      end
      S_DIV_P: begin
        rem_d  = step_rem;
        dvd_d  = quo;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BC_LAST) begin
          if ((quo >> CNT_W) != '0 || quo < DIV_W'(2)) begin
            state_d  = S_IDLE;
            err_fire = 1'b1;
            err_code = 3'd5;
          end else begin
            state_d = S_DIV_H;
            per_d   = quo[CNT_W-1:0];
            dvd_d   = DIV_W'(prod);
            dvs_d   = DIV_W'(100);
            rem_d   = '0;
            bcnt_d  = '0;
          end
        end
      end
      S_DIV_H: begin
        rem_d  = step_rem;
        dvd_d  = quo;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BC_LAST) begin
          hl_d    = quo[CNT_W-1:0];
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        vld_d   = 1'b1;
        och_d   = ch_q;
        oen_d   = en_q;
        oper_d  = per_q;
        ohl_d   = hl_q;
        if (okcnt_q != 16'hFFFF) okcnt_d = okcnt_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A dropped-frame error waits for a cycle free of other pulses.
    pend_issue = pend_q && !err_fire && (state_q != S_OUT);
    pend_d     = (pend_q && !pend_issue) || new_pend;
    if (err_fire || pend_issue) begin
      err_d   = 1'b1;
      ecode_d = err_fire ? err_code : 3'd6;
      if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_vld_q  <= 1'b0;
      in_last_q <= 1'b0;
      in_data_q <= '0;
      in_user_q <= '0;
      state_q   <= S_IDLE;
      skip_q    <= 1'b0;
      drop_q    <= 1'b0;
      pend_q    <= 1'b0;
      wcnt_q    <= '0;
      ch_q      <= '0;
      freq_q    <= '0;
      duty_q    <= '0;
      en_q      <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      bcnt_q    <= '0;
      per_q     <= '0;
      hl_q      <= '0;
      vld_q     <= 1'b0;
      och_q     <= '0;
      oen_q     <= 1'b0;
      oper_q    <= '0;
      ohl_q     <= '0;
      err_q     <= 1'b0;
      ecode_q   <= '0;
      okcnt_q   <= '0;
      errcnt_q  <= '0;
    end else begin
      in_vld_q  <= rx_axis_udp_tvalid;
      in_last_q <= rx_axis_udp_tlast;
      in_data_q <= rx_axis_udp_tdata;
      in_user_q <= rx_axis_udp_tuser;
      state_q   <= state_d;
      skip_q    <= skip_d;
      drop_q    <= drop_d;
      pend_q    <= pend_d;
      wcnt_q    <= wcnt_d;
      ch_q      <= ch_d;
      freq_q    <= freq_d;
      duty_q    <= duty_d;
      en_q      <= en_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      bcnt_q    <= bcnt_d;
      per_q     <= per_d;
      hl_q      <= hl_d;
      vld_q     <= vld_d;
      och_q     <= och_d;
      oen_q     <= oen_d;
      oper_q    <= oper_d;
      ohl_q     <= ohl_d;
      err_q     <= err_d;
      ecode_q   <= ecode_d;
      okcnt_q   <= okcnt_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign pwm_config_vld     = vld_q;
  assign pwm_config_channel = och_q;
  assign pwm_en             = oen_q;
  assign pwm_period         = oper_q;
  assign pwm_hlevel         = ohl_q;
  assign cfg_err            = err_q;
  assign cfg_err_code       = ecode_q;
  assign frame_ok_cnt       = okcnt_q;
  assign frame_err_cnt      = errcnt_q;
  assign busy               = busy_w;

endmodule

// File: tb/tb_pwm_config_mc.sv
// Bench for pwm_config_mc: random and directed parameter frames scored against
// an arithmetic model of the frame rules.
module tb_pwm_config_mc;

  localparam int DIV_W = 36;
  localparam int CNT_W = 28;
  localparam int LAT   = 2 * DIV_W + 2;
  localparam int EW    = 102;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      tdata;
  logic             tvalid, tlast;
  logic [7:0]       tuser;
  logic             pwm_config_vld, pwm_en, cfg_err, busy;
  logic [7:0]       pwm_config_channel;
  logic [CNT_W-1:0] pwm_period, pwm_hlevel;
  logic [2:0]       cfg_err_code;
  logic [15:0]      frame_ok_cnt, frame_err_cnt;

  pwm_config_mc dut (
    .clk                (clk),
    .rst                (rst),
    .rx_axis_udp_tdata  (tdata),
    .rx_axis_udp_tvalid (tvalid),
    .rx_axis_udp_tlast  (tlast),
    .rx_axis_udp_tuser  (tuser),
    .pwm_config_vld     (pwm_config_vld),
    .pwm_config_channel (pwm_config_channel),
    .pwm_en             (pwm_en),
    .pwm_period         (pwm_period),
    .pwm_hlevel         (pwm_hlevel),
    .cfg_err            (cfg_err),
    .cfg_err_code       (cfg_err_code),
    .frame_ok_cnt       (frame_ok_cnt),
    .frame_err_cnt      (frame_err_cnt),
    .busy               (busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic [31:0]   frame_w[$];
  logic [7:0]    frame_user;

  logic [7:0]       m_ch;
  logic             m_en;
  logic [CNT_W-1:0] m_per, m_hl;
  logic [15:0]      m_ok, m_errc;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_ev(input logic [1:0] kind, input logic [2:0] code,
                                            input logic [7:0] ch, input logic en,
                                            input logic [27:0] per, input logic [27:0] hl,
                                            input logic [31:0] c);
    return {kind, code, ch, en, per, hl, c};
  endfunction

  // Event monitor: every pulse becomes an observed event
  always @(negedge clk) begin
    if (!rst) begin
      if (pwm_config_vld || cfg_err)
        check_eq("vld_err_exclusive", {31'd0, pwm_config_vld && cfg_err}, 128'd0);
      if (pwm_config_vld)
        obs_q.push_back(pack_ev(2'd1, 3'd0, pwm_config_channel, pwm_en, pwm_period, pwm_hlevel, cyc));
      if (cfg_err)
        obs_q.push_back(pack_ev(2'd2, cfg_err_code, 8'd0, 1'b0, 28'd0, 28'd0, 32'd0));
    end
  end

  // Driver tasks
  task automatic build_frame(input int ch, input longint freq, input int duty, input int en,
                             input int len, input logic [7:0] user);
    logic [31:0] w;
    frame_w.delete();
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      case (i)
        0: w[7:0] = ch[7:0];
        1: w      = freq[31:0];
        2: w[7:0] = duty[7:0];
        4: w[0]   = en[0];
        default: ;
      endcase
      frame_w.push_back(w);
    end
    frame_user = user;
  endtask

  task automatic send_frame(output int c0);
    c0 = 0;
    for (int i = 0; i < frame_w.size(); i++) begin
      repeat ($urandom_range(0, 1)) begin
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
      end
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = frame_w[i];
      tuser  = (i == 0) ? frame_user : 8'($urandom);
      tlast  = (i == frame_w.size() - 1);
      if (tlast) c0 = cyc + 1;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Reference model: frame rules applied to the words just sent
  task automatic model_frame(input bit busy_now, input int c0);
    int n, code;
    logic [7:0] ch, duty;
    logic [31:0] freq;
    logic en;
    longint unsigned per, hl;
    n    = frame_w.size();
    ch   = frame_w[0][7:0];
    freq = (n > 1) ? frame_w[1] : 32'd0;
    duty = (n > 2) ? frame_w[2][7:0] : 8'd0;
    en   = (n > 4) ? frame_w[4][0] : 1'b0;
    code = 0;
    per  = 0;
    hl   = 0;
    if (frame_user != 8'h01) return;
    if (busy_now)          code = 6;
    else if (n != 5)       code = 1;
    else if (ch >= 8)      code = 2;
    else if (freq == 0)    code = 3;
    else if (duty > 100)   code = 4;
    else begin
      per = 64'd100000000 / longint'(freq);
      if (per >= (64'd1 << CNT_W) || per < 2) code = 5;
      else hl = (per * duty) / 100;
    end
    if (code != 0) begin
      exp_q.push_back(pack_ev(2'd2, 3'(code), 8'd0, 1'b0, 28'd0, 28'd0, 32'd0));
      m_errc++;
    end else begin
      exp_q.push_back(pack_ev(2'd1, 3'd0, ch, en, 28'(per), 28'(hl), 32'(c0 + LAT)));
      m_ch  = ch;
      m_en  = en;
      m_per = 28'(per);
      m_hl  = 28'(hl);
      m_ok++;
    end
  endtask

  task automatic settle();
    repeat (LAT + 12) @(negedge clk);
  endtask

  // Scoreboard: pair each expected event with the oldest observed one of its kind
  task automatic score();
    logic [EW-1:0] e, got;
    int idx;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = -1;
      for (int j = 0; j < obs_q.size(); j++)
        if (idx < 0 && obs_q[j][EW-1:EW-2] == e[EW-1:EW-2]) idx = j;
      got = '0;
      if (idx >= 0) begin
        got = obs_q[idx];
        obs_q.delete(idx);
      end
      check_eq((e[EW-1:EW-2] == 2'd1) ? "vld_record" : "err_event", got, e);
    end
    check_eq("extra_events", obs_q.size(), 0);
    obs_q.delete();
    check_eq("out_channel", pwm_config_channel, m_ch);
    check_eq("out_en", pwm_en, m_en);
    check_eq("out_period", pwm_period, m_per);
    check_eq("out_hlevel", pwm_hlevel, m_hl);
    check_eq("ok_cnt", frame_ok_cnt, m_ok);
    check_eq("err_cnt", frame_err_cnt, m_errc);
    check_eq("busy_idle", busy, 1'b0);
  endtask

  task automatic run_frame(input int ch, input longint freq, input int duty, input int en,
                           input int len, input logic [7:0] user);
    int c0;
    build_frame(ch, freq, duty, en, len, user);
    send_frame(c0);
    model_frame(1'b0, c0);
    settle();
    score();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_vld"}, pwm_config_vld, 1'b0);
    check_eq({tag, "_record"}, {pwm_config_channel, pwm_en, pwm_period, pwm_hlevel}, 0);
    check_eq({tag, "_err"}, {cfg_err, cfg_err_code}, 0);
    check_eq({tag, "_counts"}, {frame_ok_cnt, frame_err_cnt}, 0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int ca, cb, len;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tuser = '0;
    m_ch = '0; m_en = 1'b0; m_per = '0; m_hl = '0; m_ok = '0; m_errc = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal and duty corners
    run_frame(3, 1000, 25, 1, 5, 8'h01);
    run_frame(0, 1, 100, 1, 5, 8'h01);
    run_frame(5, 3, 0, 0, 5, 8'h01);
    // Invalid fields
    run_frame(8, 1000, 25, 1, 5, 8'h01);
    run_frame(2, 0, 25, 1, 5, 8'h01);
    run_frame(2, 1000, 101, 1, 5, 8'h01);
    run_frame(2, 60000000, 50, 1, 5, 8'h01);
    // Frame length and type
    run_frame(1, 1000, 10, 1, 4, 8'h01);
    run_frame(1, 1000, 10, 1, 6, 8'h01);
    run_frame(1, 1000, 10, 1, 1, 8'h01);
    run_frame(1, 1000, 10, 1, 5, 8'h02);

    // Second frame arrives while the first is still dividing
    build_frame(6, 2000, 50, 0, 5, 8'h01);
    send_frame(ca);
    model_frame(1'b0, ca);
    repeat (10) @(negedge clk);
    build_frame(1, 500, 30, 1, 5, 8'h01);
    send_frame(cb);
    model_frame(1'b1, cb);
    settle();
    score();

    // Reset in the middle of the second division
    build_frame(4, 1000, 25, 1, 5, 8'h01);
    send_frame(ca);
    repeat (DIV_W + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ch = '0; m_en = 1'b0; m_per = '0; m_hl = '0; m_ok = '0; m_errc = '0;
    exp_q.delete();
    obs_q.delete();
    settle();
    score();
    run_frame(3, 1000, 25, 1, 5, 8'h01);

    // Randomized frames
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: run_frame($urandom_range(0, 7), $urandom_range(1, 50000000),
                           $urandom_range(0, 100), $urandom_range(0, 1), 5, 8'h01);
        3, 4:    run_frame($urandom_range(0, 7), $urandom_range(1, 2000),
                           $urandom_range(0, 100), $urandom_range(0, 1), 5, 8'h01);
        5:       run_frame($urandom_range(8, 255), $urandom_range(1, 5000),
                           $urandom_range(0, 100), 1, 5, 8'h01);
        6:       run_frame($urandom_range(0, 7), $urandom_range(0, 1) ? 0 : $urandom_range(50000001, 99999999),
                           $urandom_range(0, 100), 1, 5, 8'h01);
        7:       run_frame($urandom_range(0, 7), $urandom_range(1, 5000),
                           $urandom_range(101, 255), 1, 5, 8'h01);
        8: begin
          len = $urandom_range(1, 6);
          if (len >= 5) len++;
          run_frame($urandom_range(0, 7), $urandom_range(1, 5000), 50, 1, len, 8'h01);
        end
        default: run_frame($urandom_range(0, 7), $urandom_range(1, 5000), 50, 1,
                           $urandom_range(1, 7), 8'($urandom_range(2, 255)));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_config_mc.md
Name: pwm_config_mc

Overview:
Next-generation PWM parameter parser. Receives PWM parameter frames on the user UDP receive stream, validates them and converts frequency and duty into counter values with an on-block sequential divider. Delivers one configuration record per valid frame to the PWM channel bank (NUM_CH channels). Sits between the UDP receive path and the per-channel PWM generators, and reports error and statistics status.

Parameters:
CLK_FREQ_HZ, 100000000, clk frequency in Hz; dividend for the period calculation.
PWM_PARAM_TYPE, 8'h01, rx tuser value identifying a PWM parameter frame.
NUM_CH, 8, number of PWM channels (1..256).
CNT_W, 28, width of the period and high-level counters.
DIV_W, 36, divider width; DIV_W >= CNT_W+7 and >= 32.

Ports:
clk  in  1  block clock
rst  in  1  reset, asynchronous, active-high
rx_axis_udp_tdata  in  32  frame word
rx_axis_udp_tvalid  in  1  word valid; no backpressure, every valid beat is consumed
rx_axis_udp_tlast  in  1  last word of frame
rx_axis_udp_tuser  in  8  frame type
pwm_config_vld  out  1  one-cycle pulse: record outputs are updated this cycle
pwm_config_channel  out  8  channel index
pwm_en  out  1  channel output enable
pwm_period  out  CNT_W  clocks per PWM period
pwm_hlevel  out  CNT_W  high-level clocks per period
cfg_err  out  1  one-cycle pulse: frame rejected
cfg_err_code  out  3  reason; held until the next cfg_err
frame_ok_cnt  out  16  accepted frames, saturating
frame_err_cnt  out  16  rejected or dropped frames, saturating
busy  out  1  calculation in progress

Behaviour:
- Reset: all outputs 0, FSM to IDLE, word counter 0. Reset is effective in any state; a partly received frame or a running division is discarded and produces no pulse.
- Input stage: all rx signals are registered once. All timing below refers to the beat that is accepted on the input register.
- Frame format: word0[7:0] channel. word1 frequency in Hz. word2[7:0] duty in percent. word3 reserved. word4[0] enable. Reserved bits are ignored.
- Frame type: tuser is sampled on word0 and applies to the whole frame. Frames with tuser != PWM_PARAM_TYPE are consumed silently up to and including tlast, with no error and no count.
- FSM states:
  - IDLE: on a valid beat with a matching type, capture word0 and go to RECV. If that beat also has tlast, the frame is a length error.
  - RECV: capture words 1..4 by word count. When tlast arrives, run the checks below and then go to DIV_P, or go to IDLE with an error.
  - DIV_P: restoring divide, 1 bit per cycle, DIV_W cycles, computing CLK_FREQ_HZ / freq.
  - DIV_H: same divider, DIV_W cycles, computing (period*duty) / 100.
  - OUT: one cycle. Drives pwm_config_vld, updates the record outputs, then returns to IDLE.
- Error checks, evaluated at tlast in priority order:
  - code 1: frame length != 5 words. A frame longer than 5 words ends at the first tlast; words after word4 are ignored and the error is reported at tlast.
  - code 2: channel >= NUM_CH.
  - code 3: freq == 0.
  - code 4: duty > 100.
  - code 5: computed period >= 2^CNT_W or period < 2. Checked at the end of DIV_P; on failure go to IDLE with no DIV_H.
  - code 6: a matching-type frame started while busy. The whole frame is dropped and the error is reported at its tlast.
- Error handling: every error pulses cfg_err for 1 cycle, increments frame_err_cnt, and leaves the record outputs unchanged.
- Arithmetic:
  - period = floor(CLK_FREQ_HZ / freq).
  - hlevel = floor(period*duty / 100), with the product taken at full width of CNT_W+7 bits.
  - duty 0 gives hlevel 0; duty 100 gives hlevel = period.
- Latency: pwm_config_vld is high exactly 2*DIV_W+2 cycles after the cycle in which the registered tlast beat is processed (74 cycles at default). frame_ok_cnt increments in the same cycle.
- busy is high from DIV_P entry until OUT, inclusive. A non-matching frame received while busy is ignored silently.
- Record outputs hold their values between pulses.
- Counters saturate at 16'hFFFF and do not wrap.
- Simultaneous events: an error pulse and vld never coincide, because the single FSM serialises them. A tvalid gap inside a frame is allowed.

Test Plan:
- Nominal frame at default parameters: ch=3, freq=1000, duty=25, en=1 -> vld pulse 74 cycles after tlast; channel=3, period=100000, hlevel=25000, en=1; frame_ok_cnt=1.
- Duty edge cases: freq=1 with duty=100 -> period=100000000, hlevel=100000000. freq=3 with duty=0 -> period=33333333, hlevel=0.
- Invalid fields:
  - ch=8 -> cfg_err, code 2.
  - freq=0 -> code 3.
  - duty=101 -> code 4.
  - freq=60000000 (period 1) -> code 5.
  - In all four cases there is no vld, the outputs are unchanged, and frame_err_cnt counts each error.
- Frame length: a 4-word frame -> code 1. A 6-word frame -> code 1. A 5-word frame with tuser=8'h02 -> no pulse and no count change.
- Busy drop: a second valid frame sent 10 cycles after the first tlast -> code 6 at its tlast; the first frame still produces vld with correct values.
- Reset during DIV_H -> all outputs 0 and no vld; the next valid frame processes normally with the nominal latency.
